// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources.
// Optional WAIT-state watchdog enabled by defining ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [DATA_W-1:0]          uart_data,
  output logic                       uart_start,
  input  logic                       uart_tx_done,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       err
);

  localparam int GW = $clog2(NUM_REQ);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  if (NUM_REQ < 2 || DATA_W < 1 || TIMEOUT_CYC < 2) begin : g_bad_params
    $error("uart_tx_arbiter: illegal parameter combination");
  end

  logic [1:0]         state;
  logic [GW-1:0]      last_grant;
  logic               sel_found;
  logic [GW-1:0]      sel_idx;
  logic [GW-1:0]      cand;
  logic [NUM_REQ-1:0] sel_onehot;
  logic [DATA_W-1:0]  sel_data;
  logic               timeout_hit;

  // Search starts one past the last served requester so the most recent
  // winner always ranks lowest among the pending requesters.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = GW'((32'(last_grant) + k) % NUM_REQ);
      if (!sel_found && req_valid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    sel_onehot = '0;
    sel_data   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (GW'(i) == sel_idx) begin
        sel_onehot[i] = 1'b1;
        sel_data      = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (state == S_START) begin
      wait_cnt <= '0;
    end else if (state == S_WAIT) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  assign timeout_hit = (state == S_WAIT) && (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      last_grant <= GW'(NUM_REQ - 1);
      req_ready  <= '0;
      uart_data  <= '0;
      uart_start <= 1'b0;
      grant_id   <= '0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      req_ready  <= '0;
      uart_start <= 1'b0;
      err        <= 1'b0;
      case (state)
        S_IDLE: begin
          if (sel_found) begin
            uart_data <= sel_data;
            grant_id  <= sel_idx;
            req_ready <= sel_onehot;
            busy      <= 1'b1;
            state     <= S_START;
          end
        end
        S_START: begin
          uart_start <= 1'b1;
          state      <= S_WAIT;
        end
        S_WAIT: begin
          // A timed-out source is recorded as served so it loses priority.
          if (uart_tx_done || timeout_hit) begin
            last_grant <= grant_id;
            err        <= timeout_hit && !uart_tx_done;
            busy       <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a byte scoreboard checked on each uart_start.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int DATA_W      = 8;
  localparam int TIMEOUT_CYC = 100;
  localparam int GW          = 2;

  logic                      clk = 1'b0;
  logic                      rst = 1'b0;
  logic [NUM_REQ-1:0]        req_valid = '0;
  logic [NUM_REQ*DATA_W-1:0] req_data = '0;
  logic [NUM_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]         uart_data;
  logic                      uart_start;
  logic                      uart_tx_done = 1'b0;
  logic [GW-1:0]             grant_id;
  logic                      busy;
  logic                      err;

  uart_tx_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .DATA_W     (DATA_W),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .uart_data   (uart_data),
    .uart_start  (uart_start),
    .uart_tx_done(uart_tx_done),
    .grant_id    (grant_id),
    .busy        (busy),
    .err         (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [GW-1:0]     id;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   starts = 0;
  int   pushes = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every uart_start pulse must carry the next byte the bench expects.
  exp_t mon_e;
  always @(negedge clk) begin
    if (uart_start === 1'b1) begin
      starts++;
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL sb_unexpected_start observed=%0h expected=none", uart_data);
      end
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("sb_id", 32'(grant_id), 32'(mon_e.id));
        check("sb_data", 32'(uart_data), 32'(mon_e.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int id, input logic [DATA_W-1:0] d);
    exp_t e;
    e.id   = GW'(id);
    e.data = d;
    sb.push_back(e);
    pushes++;
  endtask

  task automatic set_byte(input int i, input logic [DATA_W-1:0] v);
    req_data[i*DATA_W +: DATA_W] = v;
  endtask

  task automatic do_reset();
    req_valid = '0;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic accept(input int id, input logic [DATA_W-1:0] d);
    int n;
    logic [NUM_REQ-1:0] oh;
    n  = 0;
    oh = NUM_REQ'(1) << id;
    do begin
      tick();
      n++;
    end while (req_ready === '0 && n < 20);
    check("accept_ready", 32'(req_ready), 32'(oh));
    check("accept_grant", 32'(grant_id), 32'(id));
    check("accept_data", 32'(uart_data), 32'(d));
    check("accept_busy", 32'(busy), 32'd1);
    check("accept_nostart", 32'(uart_start), 32'd0);
  endtask

  task automatic start_check();
    tick();
    check("start_pulse", 32'(uart_start), 32'd1);
    check("start_ready_low", 32'(req_ready), 32'd0);
    check("start_busy", 32'(busy), 32'd1);
  endtask

  task automatic finish(input int w);
    repeat (w) tick();
    check("wait_busy", 32'(busy), 32'd1);
    uart_tx_done = 1'b1;
    tick();
    uart_tx_done = 1'b0;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_nostart", 32'(uart_start), 32'd0);
  endtask

  logic seen_err;

  initial begin
    repeat (3) tick();
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_start", 32'(uart_start), 32'd0);
    check("rst_data", 32'(uart_data), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b1;
    tick();

    // tx_done while idle is ignored
    uart_tx_done = 1'b1;
    tick();
    uart_tx_done = 1'b0;
    tick();
    check("idle_done_busy", 32'(busy), 32'd0);
    check("idle_done_start", 32'(uart_start), 32'd0);

    // Single request from requester 2
    set_byte(2, 8'hA5);
    req_valid = 4'b0100;
    push(2, 8'hA5);
    accept(2, 8'hA5);
    req_valid = '0;
    start_check();
    finish(5);

    // All four at once after a fresh reset
    do_reset();
    set_byte(0, 8'h10);
    set_byte(1, 8'h21);
    set_byte(2, 8'h32);
    set_byte(3, 8'h43);
    for (int i = 0; i < 4; i++) push(i, 8'h10 + 8'(i * 8'h11));
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      accept(i, 8'h10 + 8'(i * 8'h11));
      req_valid[i] = 1'b0;
      start_check();
      finish(4);
    end

    // Requester 1 always pending, requester 3 joins mid-frame
    set_byte(1, 8'h51);
    req_valid = 4'b0010;
    push(1, 8'h51);
    accept(1, 8'h51);
    set_byte(1, 8'h52);
    set_byte(3, 8'hC3);
    req_valid[3] = 1'b1;
    push(3, 8'hC3);
    push(1, 8'h52);
    start_check();
    finish(4);
    accept(3, 8'hC3);
    set_byte(3, 8'hC4);
    push(3, 8'hC4);
    start_check();
    finish(4);
    accept(1, 8'h52);
    req_valid[1] = 1'b0;
    start_check();
    finish(4);
    accept(3, 8'hC4);
    req_valid[3] = 1'b0;
    start_check();
    finish(4);

    // tx_done during the START cycle must not end the frame
    set_byte(0, 8'h77);
    req_valid = 4'b0001;
    push(0, 8'h77);
    accept(0, 8'h77);
    req_valid = '0;
    uart_tx_done = 1'b1;
    tick();
    uart_tx_done = 1'b0;
    check("early_done_start", 32'(uart_start), 32'd1);
    check("early_done_busy", 32'(busy), 32'd1);
    repeat (5) tick();
    check("early_done_still_wait", 32'(busy), 32'd1);
    check("early_done_nostart", 32'(uart_start), 32'd0);
    finish(0);

    // Asynchronous reset in the first WAIT cycle, before the monitor samples
    set_byte(2, 8'h88);
    req_valid = 4'b0100;
    accept(2, 8'h88);
    req_valid = '0;
    tick();
    check("pre_rst_start", 32'(uart_start), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("async_busy", 32'(busy), 32'd0);
    check("async_ready", 32'(req_ready), 32'd0);
    check("async_start", 32'(uart_start), 32'd0);
    check("async_data", 32'(uart_data), 32'd0);
    set_byte(0, 8'hD0);
    set_byte(1, 8'hD1);
    set_byte(2, 8'hD2);
    set_byte(3, 8'hD3);
    req_valid = 4'b1111;
    #3;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) push(i, 8'hD0 + 8'(i));
    for (int i = 0; i < 4; i++) begin
      accept(i, 8'hD0 + 8'(i));
      req_valid[i] = 1'b0;
      start_check();
      finish(3);
    end

    // tx_done never arrives
    set_byte(0, 8'h60);
    set_byte(1, 8'h61);
    req_valid = 4'b0011;
    push(0, 8'h60);
    push(1, 8'h61);
    accept(0, 8'h60);
    req_valid[0] = 1'b0;
    start_check();
`ifdef ARB_TIMEOUT_EN
    seen_err = 1'b0;
    repeat (99) begin
      tick();
      seen_err = seen_err | err;
    end
    check("to_no_early_err", 32'(seen_err), 32'd0);
    check("to_busy_before", 32'(busy), 32'd1);
    tick();
    check("to_err_pulse", 32'(err), 32'd1);
    check("to_idle", 32'(busy), 32'd0);
    accept(1, 8'h61);
    check("to_err_one_cycle", 32'(err), 32'd0);
    req_valid[1] = 1'b0;
    start_check();
    finish(3);
`else
    seen_err = 1'b0;
    repeat (150) begin
      tick();
      seen_err = seen_err | err;
    end
    check("noto_err", 32'(seen_err), 32'd0);
    check("noto_busy", 32'(busy), 32'd1);
    finish(0);
    accept(1, 8'h61);
    req_valid[1] = 1'b0;
    start_check();
    finish(3);
`endif

    repeat (3) tick();
    check("sb_empty", 32'(sb.size()), 32'd0);
    check("start_count", 32'(starts), 32'(pushes));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter among NUM_REQ byte sources using round-robin arbitration.
- Accepts a byte from the granted requester through a valid/ready handshake.
- Drives the UART top's tx_data_in/start_tx pair and waits for tx_done before serving the next request.
- Sits between on-chip producers (status, debug, command response) and the existing UART top, ahead of tx_data_in/start_tx/tx_done.

Parameters:
- NUM_REQ, 4, number of requesters (>= 2).
- DATA_W, 8, byte width; must match the UART tx_data_in width.
- TIMEOUT_CYC, 65535, WAIT-state watchdog limit in clk cycles. Used only with ARB_TIMEOUT_EN. The default covers 10 bits at 9600 baud / 50 MHz (52080 cycles).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester byte-pending flag.
- req_data  in  NUM_REQ*DATA_W  flattened bytes; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  one-cycle, one-hot accept pulse.
- uart_data  out  DATA_W  byte to UART tx_data_in; held stable from accept until return to IDLE.
- uart_start  out  1  one-cycle pulse to UART start_tx.
- uart_tx_done  in  1  UART tx_done; one-cycle pulse at end of frame.
- grant_id  out  $clog2(NUM_REQ)  index of the requester currently being served.
- busy  out  1  high whenever state != IDLE.
- err  out  1  one-cycle timeout pulse (always present; tied 0 when the feature is off).

Behaviour:
- Reset (rst=0, asynchronous) forces:
  - state=IDLE.
  - req_ready=0, uart_start=0, uart_data=0, grant_id=0, busy=0, err=0.
  - last_grant=NUM_REQ-1, so requester 0 has first priority.
- All outputs are registered.
- FSM states: IDLE, START, WAIT.
- IDLE:
  - At edge E, if any req_valid is set, select the first set bit searching from last_grant+1 upward, wrapping modulo NUM_REQ.
  - At E: capture that requester's req_data into uart_data, set grant_id, set req_ready[grant]=1 for exactly one cycle, move to START.
  - If no req_valid is set, stay in IDLE.
- START: at the next edge, set uart_start=1 for exactly one cycle and move to WAIT. Any uart_tx_done seen in the START cycle is ignored.
- WAIT:
  - Stay until uart_tx_done=1 is sampled.
  - Then set last_grant=grant_id and return to IDLE.
  - uart_data and grant_id keep their values until the next grant.
- Latency:
  - req_valid sampled at edge E → req_ready high in cycle E..E+1.
  - uart_start high in cycle E+1..E+2.
  - Minimum spacing between successive uart_start pulses = frame time + 3 cycles.
- Requester rules:
  - Hold req_valid and req_data stable until req_ready is seen.
  - Deassert or advance to the next byte on the cycle after req_ready.
  - A requester may withdraw req_valid before it is granted; nothing is sent for it.
- Fairness: a requester that keeps req_valid high cannot be granted twice in a row while another requester is pending.
- Simultaneous events:
  - Multiple req_valid bits → round-robin decides.
  - New req_valid during START/WAIT → held pending and arbitrated in the next IDLE.
  - uart_tx_done while in IDLE → ignored.
- Reset mid-operation: all state clears immediately. The arbiter does not abort a frame already inside the UART; the UART has its own reset.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYC-1 without uart_tx_done, the FSM returns to IDLE, err pulses for one cycle, and last_grant=grant_id so the stuck source loses priority.
  - The counter is sized $clog2(TIMEOUT_CYC+1).
- When undefined: no counter; WAIT waits indefinitely; err is constant 0.

Test Plan:
- Single request: reset, req_valid[2]=1, req_data byte2=8'hA5.
  - Expect req_ready=4'b0100 for one cycle, uart_start one cycle later, uart_data=8'hA5, grant_id=2.
  - With UART loopback, expect rx_data_out=8'hA5.
- All four requesters valid simultaneously with bytes 8'h10/8'h21/8'h32/8'h43.
  - Expect grant order 0,1,2,3 and four uart_start pulses each following a uart_tx_done.
  - Expect busy low only between frames.
- Requester 1 continuously valid while requester 3 asserts valid mid-frame.
  - Expect grant order 1,3,1,3 with no back-to-back grant to requester 1.
- uart_tx_done stub pulse injected during the START cycle.
  - Expect it ignored; the FSM stays in WAIT until the next pulse.
  - Expect exactly one accepted byte per uart_start.
- rst driven low during WAIT, asynchronously between clock edges.
  - Expect busy, req_ready, uart_start to drop to 0 immediately.
  - After release, requester 0 wins a 4'b1111 request.
- ARB_TIMEOUT_EN with TIMEOUT_CYC=100 and uart_tx_done tied 0.
  - Expect err pulse 100 cycles after entering WAIT, return to IDLE, and the next pending requester granted.
  - Without the macro, expect busy to stay high and err to stay 0.
